// File: rtl/cv32e40p_register_file_ecc_writer.sv
// rtl/cv32e40p_register_file_ecc_writer.sv - SEC Hamming write port with background scrub FIFO
// Core writes win; queued scrubs fill idle cycles and are cancelled by newer core writes.
module cv32e40p_register_file_ecc_writer #(
  parameter int ADDR_WIDTH  = 5,
  parameter int SCRUB_DEPTH = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_a_i,
  input  logic [ADDR_WIDTH-1:0] waddr_a_i,
  input  logic [31:0]           wdata_a_i,
  input  logic                  scrub_valid_i,
  input  logic [ADDR_WIDTH-1:0] scrub_addr_i,
  input  logic [31:0]           scrub_data_i,
  output logic                  scrub_ready_o,
  output logic                  rf_we_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [37:0]           rf_wdata_o,
  output logic                  scrub_busy_o,
  output logic                  scrub_drop_o,
  output logic [CNT_WIDTH-1:0]  scrub_cnt_o
);

  localparam int PTR_W = (SCRUB_DEPTH > 1) ? $clog2(SCRUB_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(SCRUB_DEPTH);

  // Data fills the non-power-of-two positions in order; parity gives even coverage.
  function automatic logic [37:0] encode(input logic [31:0] d);
    logic [37:0] cw;
    logic [5:0]  j;
    logic        par;
    cw = '0;
    j  = '0;
    for (int i = 0; i < 38; i++) begin
      if (((i + 1) & i) != 0) begin
        cw[i] = d[j[4:0]];
        j     = j + 6'd1;
      end
    end
    for (int k = 0; k < 6; k++) begin
      par = 1'b0;
      for (int i = 0; i < 38; i++) begin
        if (((((i + 1) >> k) & 1) != 0) && (((i + 1) & i) != 0)) begin
          par = par ^ cw[i];
        end
      end
      cw[(1 << k) - 1] = par;
    end
    return cw;
  endfunction

  logic                  fifo_valid [SCRUB_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr  [SCRUB_DEPTH];
  logic [31:0]           fifo_data  [SCRUB_DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W:0]        count;

  logic core_wr;
  logic push;
  logic pop;
  logic scrub_issue;

  assign core_wr       = we_a_i && (waddr_a_i != '0);
  assign scrub_ready_o = (count != FULL);
  assign scrub_busy_o  = (count != '0);
  // A scrub racing a core write to the same register is already stale.
  assign push          = scrub_valid_i && scrub_ready_o && (scrub_addr_i != '0) &&
                         !(core_wr && (scrub_addr_i == waddr_a_i));
  assign pop           = !core_wr && scrub_busy_o;
  assign scrub_issue   = pop && fifo_valid[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SCRUB_DEPTH; i++) begin
        fifo_valid[i] <= 1'b0;
        fifo_addr[i]  <= '0;
        fifo_data[i]  <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < SCRUB_DEPTH; i++) begin
        if (core_wr && (fifo_addr[i] == waddr_a_i)) begin
          fifo_valid[i] <= 1'b0;
        end
      end
      if (push) begin
        fifo_valid[wr_ptr] <= 1'b1;
        fifo_addr[wr_ptr]  <= scrub_addr_i;
        fifo_data[wr_ptr]  <= scrub_data_i;
        wr_ptr             <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_o      <= 1'b0;
      rf_waddr_o   <= '0;
      rf_wdata_o   <= '0;
      scrub_drop_o <= 1'b0;
      scrub_cnt_o  <= '0;
    end else begin
      rf_we_o      <= core_wr || scrub_issue;
      scrub_drop_o <= scrub_valid_i && !scrub_ready_o;
      if (core_wr) begin
        rf_waddr_o <= waddr_a_i;
        rf_wdata_o <= encode(wdata_a_i);
      end else if (scrub_issue) begin
        rf_waddr_o <= fifo_addr[rd_ptr];
        rf_wdata_o <= encode(fifo_data[rd_ptr]);
      end
      if (scrub_issue && (scrub_cnt_o != '1)) begin
        scrub_cnt_o <= scrub_cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cv32e40p_register_file_ecc_writer.sv
// tb/tb_cv32e40p_register_file_ecc_writer.sv - scoreboard bench for the ECC write port
module tb_cv32e40p_register_file_ecc_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we_a_i;
  logic [4:0]  waddr_a_i;
  logic [31:0] wdata_a_i;
  logic        scrub_valid_i;
  logic [4:0]  scrub_addr_i;
  logic [31:0] scrub_data_i;
  logic        scrub_ready_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [37:0] rf_wdata_o;
  logic        scrub_busy_o;
  logic        scrub_drop_o;
  logic [15:0] scrub_cnt_o;

  always #5 clk = ~clk;

  cv32e40p_register_file_ecc_writer #(
    .ADDR_WIDTH(5), .SCRUB_DEPTH(2), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .we_a_i(we_a_i), .waddr_a_i(waddr_a_i), .wdata_a_i(wdata_a_i),
    .scrub_valid_i(scrub_valid_i), .scrub_addr_i(scrub_addr_i), .scrub_data_i(scrub_data_i),
    .scrub_ready_o(scrub_ready_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .scrub_busy_o(scrub_busy_o), .scrub_drop_o(scrub_drop_o), .scrub_cnt_o(scrub_cnt_o)
  );

  typedef struct packed {
    logic [4:0]  addr;
    logic [37:0] cw;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  // Hand-computed codewords
  localparam logic [37:0] CW_1    = 38'h00_0000_0007;
  localparam logic [37:0] CW_MSB  = 38'h20_8000_000A;
  localparam logic [37:0] CW_2    = 38'h00_0000_0019;
  localparam logic [37:0] CW_4    = 38'h00_0000_002A;
  localparam logic [37:0] CW_8    = 38'h00_0000_004B;
  localparam logic [37:0] CW_ONES = 38'h3F_7FFF_FFF4;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic sv, input logic [4:0] sa, input logic [31:0] sd);
    we_a_i        = we;
    waddr_a_i     = wa;
    wdata_a_i     = wd;
    scrub_valid_i = sv;
    scrub_addr_i  = sa;
    scrub_data_i  = sd;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [37:0] cw);
    exp_q.push_back('{addr: a, cw: cw});
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rf_we", rf_we_o, 0);
    chk("rst_rf_waddr", rf_waddr_o, 0);
    chk("rst_rf_wdata", rf_wdata_o, 0);
    chk("rst_ready", scrub_ready_o, 1);
    chk("rst_busy", scrub_busy_o, 0);
    chk("rst_drop", scrub_drop_o, 0);
    chk("rst_cnt", scrub_cnt_o, 0);
  endtask

  always @(negedge clk) begin : monitor
    wr_t e;
    if (rst_n === 1'b1 && rf_we_o !== 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected no write", rf_waddr_o, rf_wdata_o);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", rf_waddr_o, e.addr);
        chk("wr_data", rf_wdata_o, e.cw);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    idle();
    tick();
    chk_reset_outputs();
    tick();
    rst_n = 1'b1;
    tick();

    // Core writes over a range of data patterns
    drive(1'b1, 5'd5, 32'h0000_0001, 1'b0, 5'd0, 32'h0); expect_wr(5'd5, CW_1);    tick();
    drive(1'b1, 5'd5, 32'h8000_0000, 1'b0, 5'd0, 32'h0); expect_wr(5'd5, CW_MSB);  tick();
    drive(1'b1, 5'd6, 32'h0000_0000, 1'b0, 5'd0, 32'h0); expect_wr(5'd6, 38'h0);   tick();
    drive(1'b1, 5'd7, 32'h0000_0002, 1'b0, 5'd0, 32'h0); expect_wr(5'd7, CW_2);    tick();
    drive(1'b1, 5'd8, 32'h0000_0004, 1'b0, 5'd0, 32'h0); expect_wr(5'd8, CW_4);    tick();
    drive(1'b1, 5'd9, 32'h0000_0008, 1'b0, 5'd0, 32'h0); expect_wr(5'd9, CW_8);    tick();
    drive(1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0); expect_wr(5'd31, CW_ONES); tick();
    idle();
    tick();
    chk("hold_waddr", rf_waddr_o, 31);
    chk("hold_wdata", rf_wdata_o, CW_ONES);
    tick();

    // Plain scrub: push then pop in the next idle cycle
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h0000_0001); expect_wr(5'd3, CW_1);
    tick();
    chk("t2_busy_pending", scrub_busy_o, 1);
    idle();
    tick();
    chk("t2_cnt", scrub_cnt_o, 1);
    chk("t2_busy_done", scrub_busy_o, 0);
    tick();

    // Scrub stalls behind three core writes
    drive(1'b1, 5'd9, 32'h2, 1'b1, 5'd7, 32'h8); expect_wr(5'd9, CW_2); tick();
    chk("t3_busy_a", scrub_busy_o, 1);
    drive(1'b1, 5'd9, 32'h2, 1'b0, 5'd0, 32'h0); expect_wr(5'd9, CW_2); tick();
    chk("t3_busy_b", scrub_busy_o, 1);
    drive(1'b1, 5'd9, 32'h2, 1'b0, 5'd0, 32'h0); expect_wr(5'd9, CW_2); tick();
    chk("t3_busy_c", scrub_busy_o, 1);
    idle(); expect_wr(5'd7, CW_8);
    tick();
    chk("t3_busy_done", scrub_busy_o, 0);
    chk("t3_cnt", scrub_cnt_o, 2);
    tick();

    // Pending scrub cancelled by a newer core write to the same register
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'hFFFF_FFFF); tick();
    chk("t4_busy_pending", scrub_busy_o, 1);
    drive(1'b1, 5'd4, 32'h1, 1'b0, 5'd0, 32'h0); expect_wr(5'd4, CW_1); tick();
    chk("t4_busy_invalid", scrub_busy_o, 1);
    idle();
    tick();
    chk("t4_busy_popped", scrub_busy_o, 0);
    tick();
    chk("t4_cnt", scrub_cnt_o, 2);

    // Same-cycle scrub and core write to one register; scrub to register 0
    drive(1'b1, 5'd10, 32'h0, 1'b1, 5'd10, 32'h1); expect_wr(5'd10, 38'h0); tick();
    chk("same_cycle_busy", scrub_busy_o, 0);
    idle();
    tick();
    chk("same_cycle_drop", scrub_drop_o, 0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1); tick();
    chk("scrub_r0_busy", scrub_busy_o, 0);
    idle();
    tick();

    // Fill the FIFO under core writes, overflow once, then drain in order
    drive(1'b1, 5'd9, 32'h1, 1'b1, 5'd1, 32'hFFFF_FFFF); expect_wr(5'd9, CW_1); tick();
    drive(1'b1, 5'd9, 32'h1, 1'b1, 5'd2, 32'h8000_0000); expect_wr(5'd9, CW_1); tick();
    chk("t5_ready_full", scrub_ready_o, 0);
    drive(1'b1, 5'd9, 32'h1, 1'b1, 5'd6, 32'h1); expect_wr(5'd9, CW_1); tick();
    chk("t5_drop_pulse", scrub_drop_o, 1);
    chk("t5_busy", scrub_busy_o, 1);
    drive(1'b1, 5'd9, 32'h1, 1'b0, 5'd0, 32'h0); expect_wr(5'd9, CW_1); tick();
    chk("t5_drop_clear", scrub_drop_o, 0);
    idle();
    expect_wr(5'd1, CW_ONES);
    expect_wr(5'd2, CW_MSB);
    tick();
    tick();
    chk("t5_busy_done", scrub_busy_o, 0);
    chk("t5_cnt", scrub_cnt_o, 4);
    tick();

    // Reset with two scrubs pending; the in-flight core write is killed by reset
    drive(1'b1, 5'd9, 32'h2, 1'b1, 5'd11, 32'h1); expect_wr(5'd9, CW_2); tick();
    drive(1'b1, 5'd9, 32'h8, 1'b1, 5'd12, 32'h2); tick();
    chk("t6_busy_before", scrub_busy_o, 1);
    rst_n = 1'b0;
    idle();
    #1;
    chk_reset_outputs();
    tick();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("t6_busy_after", scrub_busy_o, 0);
    chk("t6_cnt_after", scrub_cnt_o, 0);

    // Core write to register 0 is ignored
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0); tick();
    chk("r0_no_we", rf_we_o, 0);
    idle();
    tick();
    tick();

    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cv32e40p_register_file_ecc_writer.md
Name: cv32e40p_register_file_ecc_writer

Overview:
Write-side companion of the register-file Hamming decoder. It encodes 32-bit write data into 38-bit SEC Hamming codewords and drives the ECC register-file write port through one registered stage. It also accepts scrub requests (corrected data for a faulty register, raised from the read side), buffers them in a small FIFO, and writes them back in cycles with no core write. Stale scrub entries are cancelled.

Parameters:
ADDR_WIDTH, 5, register address width
SCRUB_DEPTH, 2, scrub FIFO entries (power of two, >=2)
CNT_WIDTH, 16, width of saturating scrub counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
we_a_i  in  1  core write enable
waddr_a_i  in  ADDR_WIDTH  core write address
wdata_a_i  in  32  core write data
scrub_valid_i  in  1  scrub request valid
scrub_addr_i  in  ADDR_WIDTH  register to scrub
scrub_data_i  in  32  corrected data to write back
scrub_ready_o  out  1  FIFO can accept (= not full)
rf_we_o  out  1  register-file write enable
rf_waddr_o  out  ADDR_WIDTH  register-file write address
rf_wdata_o  out  38  encoded codeword
scrub_busy_o  out  1  FIFO non-empty
scrub_drop_o  out  1  one-cycle pulse: scrub request refused because FIFO full
scrub_cnt_o  out  CNT_WIDTH  scrub writes issued, saturating

Behaviour:
- Codeword layout: bit i holds Hamming position i+1.
  - Parity bits sit at indices 0,1,3,7,15,31.
  - Data map: d0->2; d1..d3->4..6; d4..d10->8..14; d11..d25->16..30; d26..d31->32..37.
  - Parity at index 2^k-1 = XOR of every data index i where bit k of (i+1) is 1. This gives even parity, so a clean codeword decodes to syndrome 0.
- Async reset: rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, scrub_drop_o=0, scrub_cnt_o=0, FIFO empty. This makes scrub_ready_o=1 and scrub_busy_o=0.
- Latency: one cycle. The write selected in cycle N appears on the rf_* outputs in cycle N+1. rf_we_o is high for exactly one cycle per write.
- Selection each cycle, in priority order:
  1. If we_a_i && waddr_a_i!=0: issue the core write (encode wdata_a_i).
  2. Else if the FIFO head entry is valid: pop it and issue a scrub write.
  3. Else if the FIFO head entry is invalid: pop it silently with rf_we_o=0 next cycle.
  4. Else: idle, rf_we_o=0.
- Address 0 is never written. Core writes to 0 are ignored and scrub requests to 0 are discarded on push.
- FIFO:
  - Circular, with rd/wr pointers plus an occupancy count; each entry holds {valid, addr, data}.
  - Push happens when scrub_valid_i && scrub_ready_o.
  - scrub_ready_o depends only on registered occupancy. A pop in the same cycle does not free a slot for that cycle's push.
  - Simultaneous push and pop is legal when 0 < count < SCRUB_DEPTH; count is unchanged.
  - The pointers wrap modulo SCRUB_DEPTH.
- Stale cancellation: an accepted core write (we_a_i && waddr_a_i!=0) clears the valid bit of every FIFO entry with a matching address.
  - An incoming scrub to that same address in the same cycle is discarded. This is not a drop.
- Drop reporting: scrub_drop_o is registered. It is 1 in cycle N+1 iff scrub_valid_i && !scrub_ready_o in cycle N.
- scrub_cnt_o increments by 1 when a valid scrub write is issued, and holds at all-ones once saturated.
- Outputs rf_waddr_o/rf_wdata_o hold their last values when rf_we_o=0.
- Reset mid-operation clears all pending scrubs; nothing is written after reset.

Test Plan:
1. Core write addr 5, data 32'h0000_0001 -> next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=38'h00_0000_0007. Data 32'h8000_0000 -> 38'h20_8000_000A. Data 0 -> 0.
2. Scrub addr 3, data 32'h0000_0001, no core write -> push, then pop. rf_we_o=1 with addr 3 and codeword 38'h00_0000_0007 two cycles after the request; scrub_cnt_o=1; scrub_busy_o back to 0.
3. Scrub addr 7 pushed, then core writes to addr 9 held for 3 cycles -> scrub stalls and scrub_busy_o=1. It issues in the first cycle with we_a_i=0 and appears one cycle later.
4. Scrub addr 4 pending, then core write addr 4 -> entry invalidated, popped silently, no rf_we_o for addr 4 from the scrub, and scrub_cnt_o unchanged.
5. With we_a_i held high, push 2 scrubs (addrs 1,2), then a third (addr 6) -> scrub_ready_o=0, third refused, scrub_drop_o pulses once. After we_a_i drops, scrubs 1 then 2 issue in order.
6. Assert rst_n=0 with 2 scrubs pending -> all outputs take their reset values, the FIFO is empty, and no scrub write follows the release of reset. Separately, a core write to addr 0 -> rf_we_o stays 0.
